morse_char_scheduler: RTL and testbench
=======================================

# morse_char_scheduler

Sits between `symbol_rx` and the character sink (UART TX / display writer).
- Accepts decoded symbol-bytes (`tdata`/`tsize` pulses) and translates them to ASCII through the package lookup.
- Applies word-spacing and line-wrap policy, and sequences CR/LF insertion.
- Buffers the resulting character stream in a small FIFO drained over a valid/ready handshake.
- It is the only block allowed to schedule writes into the output character stream.

## Interface
- `DEPTH`, 8: output FIFO depth in characters, power of two, ≥2.
- `LINE_LEN`, 32: printable characters per line before automatic CR/LF, ≥2.
- `UNKNOWN_CHAR_EN`, 1: 1 = unmapped codes emit `'?'` (0x3F); 0 = they are dropped.
- `clk` in 1: single clock; everything below is synchronous to its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sym_tvalid_i` in 1: one-cycle pulse per received symbol-byte; no backpressure.
- `sym_tdata_i` in `MORSE_CHAR_WIDTH_MAX_C` (5): bit i = i-th symbol, 1 = dash, 0 = dot.
- `sym_tsize_i` in `MORSE_SIZE_WIDTH_MAX_C` (3): symbol count 1..5, or `MORSE_SPACE_SIZE_C` (7) for word space.
- `m_tvalid_o` out 1: output character valid.
- `m_tdata_o` out 8: ASCII character.
- `m_tready_i` in 1: sink accepts; a transfer occurs when `m_tvalid_o && m_tready_i`.
- `overflow_o` out 1: sticky; a symbol-byte was lost. Cleared only by reset.
- `column_o` out `$clog2(LINE_LEN+1)`: current column, 0..`LINE_LEN`.

## Operation
- Every output resets to 0. FSM resets to `S_RUN`. FIFO resets empty. Pending register resets empty. `last_space_r` resets to 1.
- Input stage, cycle of `sym_tvalid_i`:
  - Size 0 or 6: ignored, no state change.
  - Size 7: a space request.
  - Size 1..5: looked up via package function `morse_to_ascii(data,size)`, which returns 0x00 when the code is unmapped.
  - Unmapped code: becomes 0x3F if `UNKNOWN_CHAR_EN`, otherwise dropped.
  - A surviving character is loaded into the 1-entry pending register.
  - If the pending register is already full, the new byte is dropped and `overflow_o` sets; the pending contents are kept.
- Space policy: a space is written only if `last_space_r==0` and `column_o!=0`; otherwise it is discarded silently (no overflow). Consecutive spaces therefore collapse, and leading spaces are suppressed.
- FSM states:
  - `S_RUN`: if pending is valid and the FIFO is not full, write pending to the FIFO and clear pending. `column` += 1 and `last_space_r` = (char==0x20). If the new column == `LINE_LEN`, go to `S_CR`.
  - `S_CR`: when FIFO not full, write 0x0D and go to `S_LF`.
  - `S_LF`: when FIFO not full, write 0x0A, set column=0 and `last_space_r`=1, go to `S_RUN`.
- Pending is never written to the FIFO in `S_CR` or `S_LF`. Input arriving during these states is held in pending.
- Exactly one FIFO write per cycle maximum.
- A FIFO read and a FIFO write in the same cycle when full are not permitted. The full flag is evaluated before the read, so a full FIFO blocks the write for that cycle.
- Output side: the FIFO is first-word-fall-through. `m_tdata_o` is stable while `m_tvalid_o` is high and `m_tready_i` is low.
- Reset mid-operation discards the FIFO, pending register, column and FSM state immediately (asynchronous).

## Timing
- Latency, empty FIFO and `S_RUN`:
  - Pulse sampled at edge N loads pending.
  - The FIFO write happens at edge N+1.
  - `m_tvalid_o` is high after edge N+2.
- Throughput: one character per cycle into the FIFO. CR/LF insertion costs 2 cycles.
- Back-to-back input pulses in consecutive cycles: the second is accepted only if pending was cleared at the same edge; otherwise it overflows.
- `column_o` updates at the FIFO write edge.

## Structure
- Items that belong in `morse_decoder_pkg`:
  - `MORSE_SPACE_SIZE_C` = 7.
  - `morse_to_ascii` function covering A–Z and 0–9 (lookup on data and size).
  - ASCII constants for space, CR, LF and `'?'`.
  - The `sched_fsm_t` enum.
- One natural sub-module: `char_fifo` (parameterised FWFT sync FIFO with full/empty, width 8, depth `DEPTH`).

## Test plan
- **Single letter:** pulse data 5'b00010, size 2 ('A') after reset. Expect `m_tvalid_o` high 2 cycles later with `m_tdata_o`=0x41 and `column_o`=1.
- **Word spacing:** SOS then space then space then E, i.e. (00000,3), (00111,3), (00000,3), (x,7), (x,7), (00000,1). Expect the stream 0x53 0x4F 0x53 0x20 0x45, with only one space.
- **Leading space and unmapped code:** space immediately after reset, then (11111,4) with `UNKNOWN_CHAR_EN`=1. Expect only 0x3F; repeat with `UNKNOWN_CHAR_EN`=0 and expect no output.
- **Line wrap:** `LINE_LEN`=4, send 5×'5' (00000,5). Expect 0x35 ×4, 0x0D, 0x0A, 0x35, with `column_o` returning to 0 and then 1.
- **Backpressure/overflow:** `DEPTH`=2, `m_tready_i`=0, send 4 letters spaced 3 cycles apart. Expect 2 in FIFO, 1 pending, the 4th dropped and `overflow_o`=1. Then raise `m_tready_i` and expect the first 3 letters in order.
- **Reset mid-stream:** assert `reset` while the FIFO holds 3 characters. Expect `m_tvalid_o`, `column_o` and `overflow_o` at 0 immediately, with no stale data after release.

Source files
------------

// File: rtl/morse_decoder_pkg.sv
// morse_decoder_pkg
//   Shared constants, the scheduler FSM encoding and the Morse -> ASCII
//   lookup used by morse_char_scheduler.
//   Symbol-byte encoding: bit i is the i-th received symbol (1 = dash,
//   0 = dot); size is the number of valid symbols, or MORSE_SPACE_SIZE_C
//   for a word gap.
package morse_decoder_pkg;

    localparam int MORSE_CHAR_WIDTH_MAX_C = 5;
    localparam int MORSE_SIZE_WIDTH_MAX_C = 3;

    localparam logic [MORSE_SIZE_WIDTH_MAX_C-1:0] MORSE_SPACE_SIZE_C = 3'd7;

    localparam logic [7:0] ASCII_SPACE_C   = 8'h20;
    localparam logic [7:0] ASCII_CR_C      = 8'h0D;
    localparam logic [7:0] ASCII_LF_C      = 8'h0A;
    localparam logic [7:0] ASCII_UNKNOWN_C = 8'h3F;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_CR  = 2'd1,
        S_LF  = 2'd2
    } sched_fsm_t;

    // Returns 0x00 for any code outside A-Z / 0-9. Data bits above the
    // symbol count are don't-care and are masked off before the lookup.
    function automatic logic [7:0] morse_to_ascii(
        input logic [MORSE_CHAR_WIDTH_MAX_C-1:0] data,
        input logic [MORSE_SIZE_WIDTH_MAX_C-1:0] size
    );
        logic [MORSE_CHAR_WIDTH_MAX_C-1:0] mask;
        logic [7:0]                        key;
        logic [7:0]                        c;
        c    = 8'h00;
        mask = '0;
        if (size >= 3'd1 && size <= 3'd5)
            mask = 5'b11111 >> (3'd5 - size);
        key = {size, data & mask};
        case (key)
            {3'd2, 5'b00010}: c = "A";
            {3'd4, 5'b00001}: c = "B";
            {3'd4, 5'b00101}: c = "C";
            {3'd3, 5'b00001}: c = "D";
            {3'd1, 5'b00000}: c = "E";
            {3'd4, 5'b00100}: c = "F";
            {3'd3, 5'b00011}: c = "G";
            {3'd4, 5'b00000}: c = "H";
            {3'd2, 5'b00000}: c = "I";
            {3'd4, 5'b01110}: c = "J";
            {3'd3, 5'b00101}: c = "K";
            {3'd4, 5'b00010}: c = "L";
            {3'd2, 5'b00011}: c = "M";
            {3'd2, 5'b00001}: c = "N";
            {3'd3, 5'b00111}: c = "O";
            {3'd4, 5'b00110}: c = "P";
            {3'd4, 5'b01011}: c = "Q";
            {3'd3, 5'b00010}: c = "R";
            {3'd3, 5'b00000}: c = "S";
            {3'd1, 5'b00001}: c = "T";
            {3'd3, 5'b00100}: c = "U";
            {3'd4, 5'b01000}: c = "V";
            {3'd3, 5'b00110}: c = "W";
            {3'd4, 5'b01001}: c = "X";
            {3'd4, 5'b01101}: c = "Y";
            {3'd4, 5'b00011}: c = "Z";
            {3'd5, 5'b11111}: c = "0";
            {3'd5, 5'b11110}: c = "1";
            {3'd5, 5'b11100}: c = "2";
            {3'd5, 5'b11000}: c = "3";
            {3'd5, 5'b10000}: c = "4";
            {3'd5, 5'b00000}: c = "5";
            {3'd5, 5'b00001}: c = "6";
            {3'd5, 5'b00011}: c = "7";
            {3'd5, 5'b00111}: c = "8";
            {3'd5, 5'b01111}: c = "9";
            default:          c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/morse_char_scheduler_char_fifo.sv
// char_fifo
//   First-word-fall-through synchronous FIFO with a registered head.
//   Words land in a circular buffer and are moved into the output register
//   one cycle later, so a write into an empty FIFO shows up on rd_valid
//   two edges after the write request is presented.
//   Capacity (buffer + output register together) is DEPTH words; full is
//   a registered state, so a read in the same cycle does not free a slot
//   for a simultaneous write.
// Ports:
//   clk, reset        clock, async active-high reset
//   wr_en, wr_data    write request (ignored while full)
//   full, empty       occupancy flags
//   rd_en, rd_data    pop the head when !empty; rd_data is the head
import morse_decoder_pkg::*;

module char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    mem_cnt;    // words still in the buffer
    logic [CW-1:0]    total_cnt;  // buffer + output register
    logic             out_valid;
    logic             wr_ok, pop_out, load_out;

    assign full    = (total_cnt == DEPTH_C);
    assign empty   = !out_valid;
    assign wr_ok   = wr_en && !full;
    assign pop_out = out_valid && rd_en;
    // Refill the head whenever it is empty or being consumed this cycle.
    assign load_out = (mem_cnt != '0) && (!out_valid || pop_out);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            mem_cnt   <= '0;
            total_cnt <= '0;
            out_valid <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (wr_ok)
                wptr <= wptr + AW'(1);
            if (load_out) begin
                rptr      <= rptr + AW'(1);
                rd_data   <= mem[rptr];
                out_valid <= 1'b1;
            end else if (pop_out) begin
                out_valid <= 1'b0;
            end
            case ({wr_ok, load_out})
                2'b10:   mem_cnt <= mem_cnt + ONE_C;
                2'b01:   mem_cnt <= mem_cnt - ONE_C;
                default: mem_cnt <= mem_cnt;
            endcase
            case ({wr_ok, pop_out})
                2'b10:   total_cnt <= total_cnt + ONE_C;
                2'b01:   total_cnt <= total_cnt - ONE_C;
                default: total_cnt <= total_cnt;
            endcase
        end
    end

endmodule

// File: rtl/morse_char_scheduler.sv
// morse_char_scheduler
//   Turns decoded Morse symbol-bytes into an ASCII character stream with
//   word-space collapsing, leading-space suppression and automatic CR/LF
//   line wrapping, buffered in an FWFT FIFO for a valid/ready sink.
// Ports:
//   clk, reset                           clock, async active-high reset
//   sym_tvalid_i/sym_tdata_i/sym_tsize_i  symbol-byte pulse (no backpressure)
//   m_tvalid_o/m_tdata_o/m_tready_i       character output handshake
//   overflow_o                           sticky: a symbol-byte was lost
//   column_o                             characters written on current line
import morse_decoder_pkg::*;

module morse_char_scheduler #(
    parameter int DEPTH           = 8,
    parameter int LINE_LEN        = 32,
    parameter bit UNKNOWN_CHAR_EN = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sym_tvalid_i,
    input  logic [MORSE_CHAR_WIDTH_MAX_C-1:0] sym_tdata_i,
    input  logic [MORSE_SIZE_WIDTH_MAX_C-1:0] sym_tsize_i,
    output logic                              m_tvalid_o,
    output logic [7:0]                        m_tdata_o,
    input  logic                              m_tready_i,
    output logic                              overflow_o,
    output logic [$clog2(LINE_LEN+1)-1:0]     column_o
);

    localparam int COLW = $clog2(LINE_LEN + 1);
    localparam logic [COLW-1:0] LINE_LEN_C = COLW'(LINE_LEN);

    sched_fsm_t       state_r, state_nx;
    logic             pend_valid_r;
    logic [7:0]       pend_data_r;
    logic [COLW-1:0]  column_r;
    logic [COLW-1:0]  column_inc;
    logic             last_space_r;
    logic             overflow_r;

    logic [7:0]       lut_char;
    logic [7:0]       in_char;
    logic             in_req;
    logic             pend_pop;
    logic             fifo_wr;
    logic [7:0]       fifo_wdata;
    logic             fifo_full;
    logic             fifo_empty;

    // ---------------------------------------------------------------
    // Input stage: classify the symbol-byte into a candidate character.
    // ---------------------------------------------------------------
    always_comb begin
        lut_char = morse_to_ascii(sym_tdata_i, sym_tsize_i);
        in_char  = lut_char;
        in_req   = 1'b0;
        if (sym_tvalid_i) begin
            if (sym_tsize_i == MORSE_SPACE_SIZE_C) begin
                // Collapse repeated gaps and never start a line with a space.
                in_char = ASCII_SPACE_C;
                in_req  = !last_space_r && (column_r != '0);
            end else if (sym_tsize_i >= 3'd1 && sym_tsize_i <= 3'd5) begin
                if (lut_char != 8'h00) begin
                    in_req = 1'b1;
                end else if (UNKNOWN_CHAR_EN) begin
                    in_char = ASCII_UNKNOWN_C;
                    in_req  = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Write scheduler: at most one FIFO write per cycle, CR/LF take
    // priority over pending data once the line is full.
    // ---------------------------------------------------------------
    assign column_inc = column_r + COLW'(1);

    always_comb begin
        state_nx   = state_r;
        fifo_wr    = 1'b0;
        fifo_wdata = pend_data_r;
        pend_pop   = 1'b0;
        case (state_r)
            S_RUN: begin
                if (pend_valid_r && !fifo_full) begin
                    fifo_wr  = 1'b1;
                    pend_pop = 1'b1;
                    if (column_inc == LINE_LEN_C)
                        state_nx = S_CR;
                end
            end
            S_CR: begin
                if (!fifo_full) begin
                    fifo_wr    = 1'b1;
                    fifo_wdata = ASCII_CR_C;
                    state_nx   = S_LF;
                end
            end
            S_LF: begin
                if (!fifo_full) begin
                    fifo_wr    = 1'b1;
                    fifo_wdata = ASCII_LF_C;
                    state_nx   = S_RUN;
                end
            end
            default: state_nx = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_RUN;
            pend_valid_r <= 1'b0;
            pend_data_r  <= '0;
            column_r     <= '0;
            last_space_r <= 1'b1;
            overflow_r   <= 1'b0;
        end else begin
            state_r <= state_nx;

            // Pending slot: a new char may replace one leaving this edge.
            if (in_req && (!pend_valid_r || pend_pop)) begin
                pend_valid_r <= 1'b1;
                pend_data_r  <= in_char;
            end else if (pend_pop) begin
                pend_valid_r <= 1'b0;
            end

            if (in_req && pend_valid_r && !pend_pop)
                overflow_r <= 1'b1;

            if (pend_pop) begin
                column_r     <= column_inc;
                last_space_r <= (pend_data_r == ASCII_SPACE_C);
            end else if (state_r == S_LF && fifo_wr) begin
                column_r     <= '0;
                last_space_r <= 1'b1;
            end
        end
    end

    char_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .rd_en   (m_tready_i),
        .rd_data (m_tdata_o)
    );

    assign m_tvalid_o = !fifo_empty;
    assign overflow_o = overflow_r;
    assign column_o   = column_r;

endmodule

// File: tb/tb_morse_char_scheduler.sv
// tb_morse_char_scheduler
//   Two scheduler instances share the clock and reset:
//     A: DEPTH 8, LINE_LEN 32, unknown codes -> '?'
//     B: DEPTH 2, LINE_LEN 4,  unknown codes dropped
//   Expected characters are queued as stimulus is driven; a monitor
//   records every accepted output byte, and each test compares the two.
module tb_morse_char_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_vld, b_vld;
    logic [4:0] a_data, b_data;
    logic [2:0] a_size, b_size;
    logic       a_rdy, b_rdy;
    logic       a_mv, b_mv;
    logic [7:0] a_md, b_md;
    logic       a_ovf, b_ovf;
    logic [5:0] a_col;
    logic [2:0] b_col;

    int checks = 0;
    int errors = 0;

    logic [7:0] a_exp[$], a_obs[$], b_exp[$], b_obs[$];

    morse_char_scheduler #(.DEPTH(8), .LINE_LEN(32), .UNKNOWN_CHAR_EN(1'b1)) u_a (
        .clk(clk), .reset(reset),
        .sym_tvalid_i(a_vld), .sym_tdata_i(a_data), .sym_tsize_i(a_size),
        .m_tvalid_o(a_mv), .m_tdata_o(a_md), .m_tready_i(a_rdy),
        .overflow_o(a_ovf), .column_o(a_col)
    );

    morse_char_scheduler #(.DEPTH(2), .LINE_LEN(4), .UNKNOWN_CHAR_EN(1'b0)) u_b (
        .clk(clk), .reset(reset),
        .sym_tvalid_i(b_vld), .sym_tdata_i(b_data), .sym_tsize_i(b_size),
        .m_tvalid_o(b_mv), .m_tdata_o(b_md), .m_tready_i(b_rdy),
        .overflow_o(b_ovf), .column_o(b_col)
    );

    // Inputs change 1ns after rising edges, so the falling edge sees the
    // handshake that the next rising edge will complete.
    always @(negedge clk) begin
        if (!reset && a_mv && a_rdy) a_obs.push_back(a_md);
        if (!reset && b_mv && b_rdy) b_obs.push_back(b_md);
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse(input bit to_b, input logic [4:0] d, input logic [2:0] s);
        @(posedge clk); #1;
        if (to_b) begin b_vld = 1'b1; b_data = d; b_size = s; end
        else      begin a_vld = 1'b1; a_data = d; a_size = s; end
        @(posedge clk); #1;
        a_vld = 1'b0;
        b_vld = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        a_vld = 1'b0; a_data = '0; a_size = '0; a_rdy = 1'b0;
        b_vld = 1'b0; b_data = '0; b_size = '0; b_rdy = 1'b0;
        idle(2);
        reset = 1'b0;
        a_exp.delete(); a_obs.delete(); b_exp.delete(); b_obs.delete();
        idle(1);
    endtask

    // Waits (bounded) for the observed stream to catch up, then a few more
    // cycles so any surplus output is also captured.
    task automatic wait_obs(input bit to_b);
        for (int i = 0; i < 60; i++) begin
            if (!to_b && a_obs.size() >= a_exp.size()) break;
            if ( to_b && b_obs.size() >= b_exp.size()) break;
            idle(1);
        end
        idle(4);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_mv  !== 1'b0)  begin errors++; $display("FAIL reset_a_valid got %0h want 0", a_mv); end
        checks++; if (a_md  !== 8'h00) begin errors++; $display("FAIL reset_a_data got %0h want 0", a_md); end
        checks++; if (a_ovf !== 1'b0)  begin errors++; $display("FAIL reset_a_overflow got %0h want 0", a_ovf); end
        checks++; if (a_col !== 6'd0)  begin errors++; $display("FAIL reset_a_column got %0d want 0", a_col); end
        checks++; if (b_mv  !== 1'b0)  begin errors++; $display("FAIL reset_b_valid got %0h want 0", b_mv); end
        checks++; if (b_col !== 3'd0)  begin errors++; $display("FAIL reset_b_column got %0d want 0", b_col); end
    endtask

    task automatic test_single_letter();
        do_reset();
        pulse(1'b0, 5'b00010, 3'd2);            // 'A' sampled at edge N
        idle(1);                                // after N+1: written, not yet visible
        checks++; if (a_mv !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0h want 0", a_mv); end
        checks++; if (a_col !== 6'd1) begin errors++; $display("FAIL single_col_at_write got %0d want 1", a_col); end
        idle(1);                                // after N+2
        checks++; if (a_mv !== 1'b1) begin errors++; $display("FAIL single_valid got %0h want 1", a_mv); end
        checks++; if (a_md !== 8'h41) begin errors++; $display("FAIL single_data got %0h want 41", a_md); end
        idle(2);
        checks++; if (a_md !== 8'h41 || a_mv !== 1'b1) begin errors++; $display("FAIL single_hold got %0h/%0h want 41/1", a_md, a_mv); end
        a_exp.push_back(8'h41);
        a_rdy = 1'b1;
        wait_obs(1'b0);
        checks++; if (a_obs.size() != a_exp.size()) begin errors++; $display("FAIL single_count got %0d want %0d", a_obs.size(), a_exp.size()); end
        while (a_exp.size() != 0 && a_obs.size() != 0) begin
            logic [7:0] e, o;
            e = a_exp.pop_front(); o = a_obs.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL single_stream got %0h want %0h", o, e); end
        end
        checks++; if (a_mv !== 1'b0) begin errors++; $display("FAIL single_drained got %0h want 0", a_mv); end
    endtask

    task automatic test_word_spacing();
        logic [4:0] d [6] = '{5'b00000, 5'b00111, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        logic [2:0] s [6] = '{3'd3, 3'd3, 3'd3, 3'd7, 3'd7, 3'd1};
        do_reset();
        a_rdy = 1'b1;
        a_exp.push_back(8'h53); a_exp.push_back(8'h4F); a_exp.push_back(8'h53);
        a_exp.push_back(8'h20); a_exp.push_back(8'h45);
        for (int i = 0; i < 6; i++) begin
            pulse(1'b0, d[i], s[i]);
            idle(2);
        end
        wait_obs(1'b0);
        checks++; if (a_obs.size() != a_exp.size()) begin errors++; $display("FAIL space_count got %0d want %0d", a_obs.size(), a_exp.size()); end
        while (a_exp.size() != 0 && a_obs.size() != 0) begin
            logic [7:0] e, o;
            e = a_exp.pop_front(); o = a_obs.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL space_stream got %0h want %0h", o, e); end
        end
        checks++; if (a_col !== 6'd5) begin errors++; $display("FAIL space_column got %0d want 5", a_col); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL space_overflow got %0h want 0", a_ovf); end
    endtask

    task automatic test_leading_unmapped();
        do_reset();
        a_rdy = 1'b1;
        b_rdy = 1'b1;
        pulse(1'b0, 5'b00000, 3'd7); idle(2);
        pulse(1'b0, 5'b11111, 3'd4); idle(2);
        a_exp.push_back(8'h3F);
        pulse(1'b1, 5'b00000, 3'd7); idle(2);
        pulse(1'b1, 5'b11111, 3'd4); idle(2);
        wait_obs(1'b0);
        checks++; if (a_obs.size() != a_exp.size()) begin errors++; $display("FAIL unmapped_count got %0d want %0d", a_obs.size(), a_exp.size()); end
        while (a_exp.size() != 0 && a_obs.size() != 0) begin
            logic [7:0] e, o;
            e = a_exp.pop_front(); o = a_obs.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL unmapped_stream got %0h want %0h", o, e); end
        end
        checks++; if (a_col !== 6'd1) begin errors++; $display("FAIL unmapped_column got %0d want 1", a_col); end
        checks++; if (b_obs.size() != 0) begin errors++; $display("FAIL dropped_count got %0d want 0", b_obs.size()); end
        checks++; if (b_col !== 3'd0) begin errors++; $display("FAIL dropped_column got %0d want 0", b_col); end
        checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL dropped_overflow got %0h want 0", b_ovf); end
    endtask

    task automatic test_line_wrap();
        do_reset();
        b_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 5'b00000, 3'd5);
            idle(3);
        end
        pulse(1'b1, 5'b00000, 3'd5);
        idle(1);
        checks++; if (b_col !== 3'd4) begin errors++; $display("FAIL wrap_col_full got %0d want 4", b_col); end
        idle(8);
        checks++; if (b_col !== 3'd0) begin errors++; $display("FAIL wrap_col_zero got %0d want 0", b_col); end
        pulse(1'b1, 5'b00000, 3'd5);
        idle(3);
        checks++; if (b_col !== 3'd1) begin errors++; $display("FAIL wrap_col_one got %0d want 1", b_col); end
        for (int i = 0; i < 4; i++) b_exp.push_back(8'h35);
        b_exp.push_back(8'h0D); b_exp.push_back(8'h0A); b_exp.push_back(8'h35);
        wait_obs(1'b1);
        checks++; if (b_obs.size() != b_exp.size()) begin errors++; $display("FAIL wrap_count got %0d want %0d", b_obs.size(), b_exp.size()); end
        while (b_exp.size() != 0 && b_obs.size() != 0) begin
            logic [7:0] e, o;
            e = b_exp.pop_front(); o = b_obs.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL wrap_stream got %0h want %0h", o, e); end
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] d [4] = '{5'b00000, 5'b00001, 5'b00010, 5'b00001};  // E T A N
        logic [2:0] s [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
        do_reset();
        b_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, d[i], s[i]);
            idle(2);
        end
        checks++; if (b_ovf !== 1'b1) begin errors++; $display("FAIL bp_overflow got %0h want 1", b_ovf); end
        checks++; if (b_mv !== 1'b1 || b_md !== 8'h45) begin errors++; $display("FAIL bp_head got %0h/%0h want 1/45", b_mv, b_md); end
        checks++; if (b_col !== 3'd2) begin errors++; $display("FAIL bp_column got %0d want 2", b_col); end
        b_exp.push_back(8'h45); b_exp.push_back(8'h54); b_exp.push_back(8'h41);
        b_rdy = 1'b1;
        wait_obs(1'b1);
        checks++; if (b_obs.size() != b_exp.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", b_obs.size(), b_exp.size()); end
        while (b_exp.size() != 0 && b_obs.size() != 0) begin
            logic [7:0] e, o;
            e = b_exp.pop_front(); o = b_obs.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL bp_stream got %0h want %0h", o, e); end
        end
        checks++; if (b_col !== 3'd3) begin errors++; $display("FAIL bp_column_after got %0d want 3", b_col); end
        checks++; if (b_ovf !== 1'b1) begin errors++; $display("FAIL bp_sticky got %0h want 1", b_ovf); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        a_rdy = 1'b1;
        @(posedge clk); #1;
        a_vld = 1'b1; a_data = 5'b00000; a_size = 3'd1;   // E
        @(posedge clk); #1;
        a_data = 5'b00001; a_size = 3'd1;                  // T
        @(posedge clk); #1;
        a_data = 5'b00010; a_size = 3'd2;                  // A
        @(posedge clk); #1;
        a_vld = 1'b0;
        a_exp.push_back(8'h45); a_exp.push_back(8'h54); a_exp.push_back(8'h41);
        wait_obs(1'b0);
        checks++; if (a_obs.size() != a_exp.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", a_obs.size(), a_exp.size()); end
        while (a_exp.size() != 0 && a_obs.size() != 0) begin
            logic [7:0] e, o;
            e = a_exp.pop_front(); o = a_obs.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL b2b_stream got %0h want %0h", o, e); end
        end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %0h want 0", a_ovf); end
        checks++; if (a_col !== 6'd3) begin errors++; $display("FAIL b2b_column got %0d want 3", a_col); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        a_rdy = 1'b0;
        pulse(1'b0, 5'b00000, 3'd1); idle(1);
        pulse(1'b0, 5'b00001, 3'd1); idle(1);
        pulse(1'b0, 5'b00010, 3'd2); idle(3);
        checks++; if (a_mv !== 1'b1 || a_col !== 6'd3) begin errors++; $display("FAIL mid_prefill got %0h/%0d want 1/3", a_mv, a_col); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (a_mv !== 1'b0) begin errors++; $display("FAIL mid_valid got %0h want 0", a_mv); end
        checks++; if (a_col !== 6'd0) begin errors++; $display("FAIL mid_column got %0d want 0", a_col); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL mid_overflow got %0h want 0", a_ovf); end
        idle(2);
        reset = 1'b0;
        a_exp.delete(); a_obs.delete();
        a_rdy = 1'b1;
        idle(10);
        checks++; if (a_obs.size() != 0) begin errors++; $display("FAIL mid_stale got %0d want 0", a_obs.size()); end
        pulse(1'b0, 5'b00000, 3'd3);                        // S
        a_exp.push_back(8'h53);
        wait_obs(1'b0);
        checks++; if (a_obs.size() != a_exp.size()) begin errors++; $display("FAIL mid_count got %0d want %0d", a_obs.size(), a_exp.size()); end
        while (a_exp.size() != 0 && a_obs.size() != 0) begin
            logic [7:0] e, o;
            e = a_exp.pop_front(); o = a_obs.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL mid_stream got %0h want %0h", o, e); end
        end
    endtask

    initial begin
        reset = 1'b1;
        a_vld = 1'b0; a_data = '0; a_size = '0; a_rdy = 1'b0;
        b_vld = 1'b0; b_data = '0; b_size = '0; b_rdy = 1'b0;
        test_reset();
        test_single_letter();
        test_word_spacing();
        test_leading_unmapped();
        test_line_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
